alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
- Downstream stage of the 8-bit adder ALU; captures each produced result byte plus its C/Z/O flags into a small FIFO.
- Hands results to the consumer through a valid/ready handshake.
- Maintains sticky carry/overflow status, an operation counter, and a Z-flag consistency checker.
- Decouples the combinational adder from a consumer that may stall.

Parameters:
- DATA_W, 8, width of result byte
- DEPTH, 4, FIFO entries; power of two, at least 2
- CNT_W, 16, width of accepted-operation counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  producer presents a result
- in_ready  out  1  FIFO can accept; equals !full, with no dependence on out_ready
- in_sum  in  DATA_W  result byte from adder
- in_c  in  1  carry flag from adder
- in_z  in  1  zero flag from adder
- in_o  in  1  overflow flag from adder
- out_valid  out  1  head entry valid (FIFO not empty)
- out_ready  in  1  consumer takes head entry
- out_sum  out  DATA_W  head entry byte
- out_c  out  1  head entry carry
- out_z  out  1  head entry zero
- out_o  out  1  head entry overflow
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- sticky_c  out  1  a carry was accepted since last clear
- sticky_o  out  1  an overflow was accepted since last clear
- z_err  out  1  sticky; an accepted entry had inconsistent Z
- sticky_clr  in  1  clears sticky_c, sticky_o, z_err
- op_count  out  CNT_W  accepted entries, saturating

Behaviour:
- Push when in_valid && in_ready. Pop when out_valid && out_ready. Both are evaluated on the same rising edge.
- Reset (synchronous, active-high):
  - Pointers = 0, level = 0, out_valid = 0.
  - out_sum/out_c/out_z/out_o = 0 (head forced to 0 while empty).
  - sticky_c = sticky_o = z_err = 0, op_count = 0.
  - in_ready = 1 in the cycle after reset deasserts.
- Latency:
  - An entry pushed at edge N is visible at out_* with out_valid = 1 after edge N, when the FIFO was empty.
  - There is no combinational in-to-out path.
- Ordering: strict FIFO; out_* always show the oldest entry, held stable while out_valid && !out_ready.
- Full (level == DEPTH):
  - in_ready = 0 and no push, even if a pop occurs in the same cycle.
  - in_ready returns to 1 the cycle after a pop.
  - Producer holds in_* while in_valid && !in_ready.
- Empty:
  - out_valid = 0 and out_ready is ignored; level never underflows.
- Simultaneous push and pop when 0 < level < DEPTH: level unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally; a separate level counter gives the full/empty decision.
- Sticky flags (updated only on a push):
  - sticky_c |= in_c; sticky_o |= in_o.
  - z_err set if in_z != ((in_sum == 0) && !in_c). This holds because Z reflects the full 9-bit result.
  - sticky_clr and a setting push in the same cycle: set wins (result 1).
  - sticky_clr alone: result 0 next cycle.
- op_count increments by 1 per push and saturates at all-ones; it is cleared only by reset.
- Reset asserted mid-operation discards all entries immediately on that edge; no partial state survives.

Decomposition:
- Shared package alu_pkg:
  - ALU_DATA_W = 8.
  - Packed entry typedef alu_entry_t {sum[7:0], c, z, o}, 11 bits total.
  - Function z_expected(sum, c).
- One sub-module, alu_fifo_mem: DEPTH x alu_entry_t register array with a write port (we, waddr, wdata) and an asynchronous read port (raddr → rdata). The storage array is not cleared on reset.
- All control (pointers, level, flags, counter) lives in alu_result_fifo.

Test Plan:
1. Reset, then push {sum=8'h3C, c=0, z=0, o=0} with out_ready=0 → next cycle out_valid=1, out_sum=8'h3C, level=1, op_count=1, all sticky flags 0.
2. Push 4 entries (8'h01..8'h04) with out_ready=0 → level=4, in_ready=0. Present a 5th (8'h05) while pulsing out_ready for one cycle → 8'h01 popped, 8'h05 not accepted that cycle. 8'h05 is accepted the next cycle, then pops drain in order 02, 03, 04, 05.
3. Continuous push and pop at level=2 for 10 cycles with incrementing sums → level stays 2, outputs in order, pointers wrap without loss.
4. Push {sum=8'h00, c=1, z=0, o=1} (0x80+0x80) → sticky_c=1, sticky_o=1, z_err=0. Then push {sum=8'h05, c=0, z=1, o=0} → z_err=1.
5. Assert sticky_clr in the same cycle as a push with c=1 → sticky_c stays 1. sticky_clr alone next cycle → sticky_c=0, sticky_o=0, z_err=0.
6. Assert reset with level=3 mid-stream → next cycle level=0, out_valid=0, out_sum=0, op_count=0. Force op_count to 16'hFFFE, then 3 pushes → op_count holds at 16'hFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the adder ALU result path: packed result entry and Z-flag reference.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 8;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] sum;
        logic                  c;
        logic                  z;
        logic                  o;
    } alu_entry_t;

    // Z covers the full 9-bit result, so a carry-out makes a zero byte non-zero.
    function automatic logic z_expected(input logic [ALU_DATA_W-1:0] sum, input logic c);
        return (sum == '0) && !c;
    endfunction

endpackage

// File: rtl/alu_result_fifo_if.sv
// Producer/consumer handshake and status bundle of the ALU result FIFO.
interface alu_result_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sum;
    logic              in_c;
    logic              in_z;
    logic              in_o;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic              out_c;
    logic              out_z;
    logic              out_o;
    logic [LVL_W-1:0]  level;
    logic              sticky_c;
    logic              sticky_o;
    logic              z_err;
    logic              sticky_clr;
    logic [CNT_W-1:0]  op_count;

    modport master (
        output in_valid, in_sum, in_c, in_z, in_o, out_ready, sticky_clr,
        input  in_ready, out_valid, out_sum, out_c, out_z, out_o,
        input  level, sticky_c, sticky_o, z_err, op_count
    );

    modport slave (
        input  in_valid, in_sum, in_c, in_z, in_o, out_ready, sticky_clr,
        output in_ready, out_valid, out_sum, out_c, out_z, out_o,
        output level, sticky_c, sticky_o, z_err, op_count
    );

endinterface

// File: rtl/alu_fifo_mem.sv
// Result entry storage: one write port, asynchronous read port; contents survive reset.
module alu_fifo_mem
    import alu_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  alu_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output alu_entry_t    rdata
);

    alu_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// ALU result FIFO: buffers result bytes + flags, tracks sticky status and accepted-op count.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input logic              clk,
    input logic              reset,
    alu_result_fifo_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             sticky_c_q, sticky_c_d;
    logic             sticky_o_q, sticky_o_d;
    logic             z_err_q, z_err_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    alu_entry_t       wdata;
    alu_entry_t       rdata;
    alu_entry_t       head;
    logic [DATA_W-1:0] head_sum;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    // Full blocks a push even when a pop happens on the same edge.
    assign push  = bus.in_valid && !full;
    assign pop   = bus.out_ready && !empty;

    assign wdata.sum = bus.in_sum;
    assign wdata.c   = bus.in_c;
    assign wdata.z   = bus.in_z;
    assign wdata.o   = bus.in_o;

    alu_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        sticky_c_d = sticky_c_q && !bus.sticky_clr;
        sticky_o_d = sticky_o_q && !bus.sticky_clr;
        z_err_d    = z_err_q && !bus.sticky_clr;
        op_count_d = op_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // A setting push overrides a simultaneous clear.
        if (push) begin
            if (bus.in_c) begin
                sticky_c_d = 1'b1;
            end
            if (bus.in_o) begin
                sticky_o_d = 1'b1;
            end
            if (bus.in_z != z_expected(bus.in_sum, bus.in_c)) begin
                z_err_d = 1'b1;
            end
            if (op_count_q != '1) begin
                op_count_d = op_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sticky_c_q <= 1'b0;
            sticky_o_q <= 1'b0;
            z_err_q    <= 1'b0;
            op_count_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sticky_c_q <= sticky_c_d;
            sticky_o_q <= sticky_o_d;
            z_err_q    <= z_err_d;
            op_count_q <= op_count_d;
        end
    end

    // Storage is never cleared, so the head is masked while empty.
    assign head     = empty ? '0 : rdata;
    assign head_sum = head.sum;

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_sum   = head_sum;
    assign bus.out_c     = head.c;
    assign bus.out_z     = head.z;
    assign bus.out_o     = head.o;
    assign bus.level     = level_q;
    assign bus.sticky_c  = sticky_c_q;
    assign bus.sticky_o  = sticky_o_q;
    assign bus.z_err     = z_err_q;
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: queue-based reference model plus directed vectors.
module tb_alu_result_fifo;

    logic clk;
    logic reset;

    alu_result_fifo_if #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) bus ();
    alu_result_fifo_if #(.DATA_W(8), .DEPTH(4), .CNT_W(4))  bus4 ();

    alu_result_fifo #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    alu_result_fifo #(.DATA_W(8), .DEPTH(4), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    assign bus4.in_valid   = bus.in_valid;
    assign bus4.in_sum     = bus.in_sum;
    assign bus4.in_c       = bus.in_c;
    assign bus4.in_z       = bus.in_z;
    assign bus4.in_o       = bus.in_o;
    assign bus4.out_ready  = bus.out_ready;
    assign bus4.sticky_clr = bus.sticky_clr;

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [10:0] mq[$];
    logic        m_sc, m_so, m_ze;
    int unsigned m_cnt, m_cnt4;

    typedef struct {
        logic       iv;
        logic [7:0] s;
        logic       c, z, o;
        logic       ordy, clr;
        int unsigned e_level;
        logic       e_ov;
        logic [7:0] e_sum;
        logic       e_sc, e_so, e_ze;
        int unsigned e_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic iv, input logic [7:0] s,
                              input logic c, input logic z, input logic o,
                              input logic ordy, input logic clr);
        bit do_push, do_pop;
        if (rst) begin
            mq.delete();
            m_sc = 0; m_so = 0; m_ze = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            do_push = iv && (mq.size() < 4);
            do_pop  = ordy && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({s, c, z, o});
            m_sc = (m_sc && !clr) || (do_push && c);
            m_so = (m_so && !clr) || (do_push && o);
            m_ze = (m_ze && !clr) || (do_push && (z != ((s == 8'h00) && !c)));
            if (do_push) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
    endtask

    task automatic check_all();
        logic [10:0] h;
        h = (mq.size() > 0) ? mq[0] : 11'h000;
        chk("level",     32'(bus.level),     32'(mq.size()));
        chk("in_ready",  32'(bus.in_ready),  32'(mq.size() < 4));
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
        chk("out_sum",   32'(bus.out_sum),   32'(h[10:3]));
        chk("out_c",     32'(bus.out_c),     32'(h[2]));
        chk("out_z",     32'(bus.out_z),     32'(h[1]));
        chk("out_o",     32'(bus.out_o),     32'(h[0]));
        chk("sticky_c",  32'(bus.sticky_c),  32'(m_sc));
        chk("sticky_o",  32'(bus.sticky_o),  32'(m_so));
        chk("z_err",     32'(bus.z_err),     32'(m_ze));
        chk("op_count",  32'(bus.op_count),  m_cnt);
        chk("op_count4", 32'(bus4.op_count), m_cnt4);
        chk("level4",    32'(bus4.level),    32'(mq.size()));
    endtask

    task automatic step();
        logic r, iv, c, z, o, ordy, clr;
        logic [7:0] s;
        r = reset; iv = bus.in_valid; s = bus.in_sum; c = bus.in_c; z = bus.in_z;
        o = bus.in_o; ordy = bus.out_ready; clr = bus.sticky_clr;
        @(posedge clk);
        #1;
        model_edge(r, iv, s, c, z, o, ordy, clr);
        check_all();
    endtask

    task automatic drive(input logic iv, input logic [7:0] s, input logic c, input logic z,
                         input logic o, input logic ordy, input logic clr);
        bus.in_valid = iv; bus.in_sum = s; bus.in_c = c; bus.in_z = z; bus.in_o = o;
        bus.out_ready = ordy; bus.sticky_clr = clr;
    endtask

    task automatic do_reset();
        drive(0, 8'h00, 0, 0, 0, 0, 0);
        reset = 1;
        step();
        reset = 0;
    endtask

    vec_t vt[8];
    logic [7:0] drain_exp[4];

    initial begin
        clk = 0;
        reset = 1;
        drive(0, 8'h00, 0, 0, 0, 0, 0);
        do_reset();
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_level", 32'(bus.level), 32'd0);

        // iv s c z o ordy clr | level ov sum sc so ze cnt
        vt[0] = '{1, 8'h3C, 0, 0, 0, 0, 0, 1, 1, 8'h3C, 0, 0, 0, 1};
        vt[1] = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 1};
        vt[2] = '{1, 8'h00, 1, 0, 1, 0, 0, 1, 1, 8'h00, 1, 1, 0, 2};
        vt[3] = '{1, 8'h05, 0, 1, 0, 1, 0, 1, 1, 8'h05, 1, 1, 1, 3};
        vt[4] = '{1, 8'h10, 1, 0, 0, 1, 1, 1, 1, 8'h10, 1, 0, 0, 4};
        vt[5] = '{0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 4};
        vt[6] = '{1, 8'h00, 0, 1, 0, 0, 0, 1, 1, 8'h00, 0, 0, 0, 5};
        vt[7] = '{1, 8'h00, 0, 0, 0, 0, 0, 2, 1, 8'h00, 0, 0, 1, 6};
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].iv, vt[i].s, vt[i].c, vt[i].z, vt[i].o, vt[i].ordy, vt[i].clr);
            step();
            chk($sformatf("vec%0d_level", i), 32'(bus.level), vt[i].e_level);
            chk($sformatf("vec%0d_ov", i), 32'(bus.out_valid), 32'(vt[i].e_ov));
            chk($sformatf("vec%0d_sum", i), 32'(bus.out_sum), 32'(vt[i].e_sum));
            chk($sformatf("vec%0d_sc", i), 32'(bus.sticky_c), 32'(vt[i].e_sc));
            chk($sformatf("vec%0d_so", i), 32'(bus.sticky_o), 32'(vt[i].e_so));
            chk($sformatf("vec%0d_ze", i), 32'(bus.z_err), 32'(vt[i].e_ze));
            chk($sformatf("vec%0d_cnt", i), 32'(bus.op_count), vt[i].e_cnt);
        end

        // Full FIFO: a pop on the same edge does not let the blocked push in.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 8'(i), 0, 0, 0, 0, 0);
            step();
        end
        chk("full_level", 32'(bus.level), 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1, 8'h05, 0, 0, 0, 1, 0);
        step();
        chk("full_pop_level", 32'(bus.level), 32'd3);
        chk("full_pop_head", 32'(bus.out_sum), 32'h02);
        chk("full_pop_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1, 8'h05, 0, 0, 0, 0, 0);
        step();
        chk("refill_level", 32'(bus.level), 32'd4);
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), 32'(bus.out_sum), 32'(drain_exp[i]));
            drive(0, 8'h00, 0, 0, 0, 1, 0);
            step();
        end
        chk("drained_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("empty_no_underflow", 32'(bus.level), 32'd0);

        // Steady push+pop at level 2 across pointer wrap.
        do_reset();
        drive(1, 8'h20, 0, 0, 0, 0, 0); step();
        drive(1, 8'h21, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stream%0d_head", i), 32'(bus.out_sum), 32'(8'h20 + 8'(i)));
            drive(1, 8'h22 + 8'(i), 0, 0, 0, 1, 0);
            step();
            chk($sformatf("stream%0d_level", i), 32'(bus.level), 32'd2);
        end

        // Reset mid-stream at level 3, then counter saturation on the narrow instance.
        drive(1, 8'h77, 0, 0, 0, 0, 0); step();
        chk("pre_reset_level", 32'(bus.level), 32'd3);
        reset = 1;
        drive(1, 8'h88, 1, 0, 1, 0, 0);
        step();
        reset = 0;
        chk("mid_reset_level", 32'(bus.level), 32'd0);
        chk("mid_reset_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_reset_sum", 32'(bus.out_sum), 32'd0);
        chk("mid_reset_cnt", 32'(bus.op_count), 32'd0);
        chk("mid_reset_sc", 32'(bus.sticky_c), 32'd0);
        for (int i = 0; i < 17; i++) begin
            drive(1, 8'(i + 1), 0, 0, 0, 1, 0);
            step();
        end
        chk("sat_cnt4", 32'(bus4.op_count), 32'hF);
        chk("nosat_cnt16", 32'(bus.op_count), 32'd17);

        // Randomised traffic; producer holds its inputs while stalled.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [7:0] s;
            logic c;
            if (!(bus.in_valid && !bus.in_ready)) begin
                s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                c = 1'($urandom);
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sum = s;
                bus.in_c = c;
                bus.in_o = 1'($urandom);
                bus.in_z = ($urandom_range(0, 7) == 0) ? !((s == 8'h00) && !c)
                                                        : ((s == 8'h00) && !c);
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.sticky_clr = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
